// File: rtl/nes_pad_responder_if.sv
// Pad connector bundle between the console/harness side and the responder.
// master drives buttons and the strobe/clock pins; slave answers.
interface nes_pad_responder_if;
  logic [7:0] buttons;
  logic       joy_strobe;
  logic       joy_clock;
  logic [1:0] turbo_en;
  logic       joy_data;
  logic [7:0] latched;
  logic       read_done;

  modport master (
    output buttons,
    output joy_strobe,
    output joy_clock,
    output turbo_en,
    input  joy_data,
    input  latched,
    input  read_done
  );

  modport slave (
    input  buttons,
    input  joy_strobe,
    input  joy_clock,
    input  turbo_en,
    output joy_data,
    output latched,
    output read_done
  );
endinterface

// File: rtl/nes_pad_responder.sv
// NES pad responder: emulates the 4021 shift register of a standard joypad.
// Optional turbo on A/B when PAD_TURBO_EN is defined.
module nes_pad_responder #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4,
  parameter int TURBO_FRAMES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  nes_pad_responder_if.slave   pad
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1 || TURBO_FRAMES < 1) begin : g_param_err
    $error("nes_pad_responder: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] stb_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic                   stb_syn;
  logic                   clk_syn;

  logic          stb_acc_q, stb_acc_d;
  logic          clk_acc_q, clk_acc_d;
  logic [FW-1:0] stb_fcnt_q, stb_fcnt_d;
  logic [FW-1:0] clk_fcnt_q, clk_fcnt_d;
  logic          stb_prev_q;
  logic          clk_prev_q;
  logic          stb_fall;
  logic          clk_rise;

  logic [7:0] sr_q, sr_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [7:0] latched_q, latched_d;
  logic       done_q, done_d;
  logic       joy_data_q, joy_data_d;
  logic [7:0] eff_btn;

  assign stb_syn = stb_sync_q[SYNC_STAGES-1];
  assign clk_syn = clk_sync_q[SYNC_STAGES-1];

  // Accepted level only flips after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    stb_acc_d  = stb_acc_q;
    stb_fcnt_d = '0;
    if (stb_syn != stb_acc_q) begin
      if (stb_fcnt_q == FW'(FILTER_LEN - 1))
        stb_acc_d = ~stb_acc_q;
      else
        stb_fcnt_d = stb_fcnt_q + 1'b1;
    end
  end

  always_comb begin
    clk_acc_d  = clk_acc_q;
    clk_fcnt_d = '0;
    if (clk_syn != clk_acc_q) begin
      if (clk_fcnt_q == FW'(FILTER_LEN - 1))
        clk_acc_d = ~clk_acc_q;
      else
        clk_fcnt_d = clk_fcnt_q + 1'b1;
    end
  end

  assign stb_fall = stb_prev_q & ~stb_acc_q;
  assign clk_rise = clk_acc_q & ~clk_prev_q;

`ifdef PAD_TURBO_EN
  localparam int TW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;

  logic [TW-1:0] tcnt_q;
  logic          phase_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (stb_fall) begin
      if (tcnt_q == TW'(TURBO_FRAMES - 1)) begin
        tcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        tcnt_q  <= tcnt_q + 1'b1;
      end
    end
  end

  assign eff_btn = {
    pad.buttons[7:2],
    pad.buttons[1] & ~(pad.turbo_en[1] & phase_q),
    pad.buttons[0] & ~(pad.turbo_en[0] & phase_q)
  };
`else
  assign eff_btn = pad.buttons;
`endif

  // Load and latch take precedence; a coincident clock edge is dropped.
  always_comb begin
    sr_d      = sr_q;
    bcnt_d    = bcnt_q;
    latched_d = latched_q;
    done_d    = 1'b0;
    unique case (1'b1)
      stb_acc_q: begin
        sr_d   = eff_btn;
        bcnt_d = '0;
      end
      stb_fall: begin
        latched_d = sr_q;
      end
      (clk_rise & ~stb_acc_q & ~stb_fall): begin
        sr_d = {1'b1, sr_q[7:1]};
        if (bcnt_q != 4'd8)
          bcnt_d = bcnt_q + 4'd1;
        done_d = (bcnt_q == 4'd7);
      end
      default: ;
    endcase
    joy_data_d = ~sr_d[0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stb_sync_q <= '0;
      clk_sync_q <= '0;
      stb_acc_q  <= 1'b0;
      clk_acc_q  <= 1'b0;
      stb_fcnt_q <= '0;
      clk_fcnt_q <= '0;
      stb_prev_q <= 1'b0;
      clk_prev_q <= 1'b0;
      sr_q       <= '0;
      bcnt_q     <= '0;
      latched_q  <= '0;
      done_q     <= 1'b0;
      joy_data_q <= 1'b1;
    end else begin
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], pad.joy_strobe};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], pad.joy_clock};
      stb_acc_q  <= stb_acc_d;
      clk_acc_q  <= clk_acc_d;
      stb_fcnt_q <= stb_fcnt_d;
      clk_fcnt_q <= clk_fcnt_d;
      stb_prev_q <= stb_acc_q;
      clk_prev_q <= clk_acc_q;
      sr_q       <= sr_d;
      bcnt_q     <= bcnt_d;
      latched_q  <= latched_d;
      done_q     <= done_d;
      joy_data_q <= joy_data_d;
    end
  end

  assign pad.joy_data  = joy_data_q;
  assign pad.latched   = latched_q;
  assign pad.read_done = done_q;

endmodule
